// File: rtl/accum_pkg.sv
// Shared constants and saturating-add helper for the filter accumulators.
// All arithmetic is done in a wide signed type and narrowed by the caller.
package accum_pkg;

    localparam int unsigned DefInW    = 24;
    localparam int unsigned DefAccW   = 48;
    localparam int unsigned DefWinLen = 9;
    localparam int unsigned MaxW      = 128;

    typedef logic signed [MaxW-1:0] wide_t;

    function automatic wide_t sat_max(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

    // Operands must already lie in the signed w-bit range; the raw result then fits in w+1 bits.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input logic sub,
                                      input int unsigned w, input logic sat, output logic ovf);
        wide_t sum;
        sum = sub ? (a - b) : (a + b);
        ovf = (sum > sat_max(w)) || (sum < sat_min(w));
        if (ovf && sat) begin
            sum = (sum > sat_max(w)) ? sat_max(w) : sat_min(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/accum_sat_core.sv
// Combinational add/subtract of one term into an ACC_W accumulator value,
// with optional clamp to the signed ACC_W range and an overflow flag.
module accum_sat_core
    import accum_pkg::*;
#(
    parameter int unsigned IN_W   = DefInW,
    parameter int unsigned ACC_W  = DefAccW,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0] base,
    input  logic signed [IN_W:0]    term,
    input  logic                    sub,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    wide_t base_w;
    wide_t term_w;
    wide_t res_w;
    logic  unused_res_hi;

    always_comb begin
        base_w = {{(MaxW - ACC_W){base[ACC_W-1]}}, base};
        term_w = {{(MaxW - IN_W - 1){term[IN_W]}}, term};
        res_w  = sat_add(base_w, term_w, sub, ACC_W, SAT_EN, ovf);
        // Dropping the upper bits is the modulo-2^ACC_W wrap when clamping is off.
        sum    = res_w[ACC_W-1:0];
    end

    assign unused_res_hi = ^res_w[MaxW-1:ACC_W];

endmodule

// File: rtl/accum_win.sv
// Windowed accumulator: stage 1 registers the A+C term, stage 2 folds it into the
// running sum and publishes the total after every WIN_LEN accepted samples.
module accum_win
    import accum_pkg::*;
#(
    parameter int unsigned IN_W    = DefInW,
    parameter int unsigned ACC_W   = DefAccW,
    parameter int unsigned WIN_LEN = DefWinLen,
    parameter bit          SAT_EN  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    input  logic signed [IN_W-1:0]  A_IN,
    input  logic signed [IN_W-1:0]  C_IN,
    input  logic                    ADD_SUB,
    input  logic                    CLR,
    output logic                    OUT_VALID,
    output logic signed [ACC_W-1:0] ACCUM_OUT,
    output logic                    OVF,
    output logic                    BUSY
);

    localparam int unsigned CntW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic                    accept;
    logic                    cnt_last;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic signed [IN_W:0]    term_q, term_d;
    logic                    sub_q, sub_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    last_q, last_d;
    logic                    first_q, first_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    sticky_q, sticky_d;
    logic signed [ACC_W-1:0] accum_q, accum_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] core_sum;
    logic                    core_ovf;

    always_comb begin
        accept     = IN_VALID & ~CLR;
        cnt_last   = (cnt_q == CntW'(WIN_LEN - 1));
        cnt_d      = cnt_q;
        term_d     = term_q;
        sub_d      = sub_q;
        last_d     = last_q;
        first_d    = first_q;
        s1_valid_d = accept;
        if (CLR) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d   = cnt_last ? '0 : cnt_q + CntW'(1);
            term_d  = {A_IN[IN_W-1], A_IN} + {C_IN[IN_W-1], C_IN};
            sub_d   = ADD_SUB;
            last_d  = cnt_last;
            first_d = (cnt_q == '0);
        end
    end

    assign base = first_q ? '0 : sum_q;

    accum_sat_core #(
        .IN_W   (IN_W),
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_core (
        .base (base),
        .term (term_q),
        .sub  (sub_q),
        .sum  (core_sum),
        .ovf  (core_ovf)
    );

    always_comb begin
        sum_d       = sum_q;
        sticky_d    = sticky_q;
        accum_d     = accum_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (CLR) begin
            // A last term still in stage 1 is dropped along with the rest of the window.
            sum_d    = '0;
            sticky_d = 1'b0;
        end else if (s1_valid_q) begin
            sum_d    = core_sum;
            sticky_d = (first_q ? 1'b0 : sticky_q) | core_ovf;
            if (last_q) begin
                accum_d     = core_sum;
                ovf_d       = sticky_d;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q       <= '0;
            term_q      <= '0;
            sub_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            sum_q       <= '0;
            sticky_q    <= 1'b0;
            accum_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            term_q      <= term_d;
            sub_q       <= sub_d;
            s1_valid_q  <= s1_valid_d;
            last_q      <= last_d;
            first_q     <= first_d;
            sum_q       <= sum_d;
            sticky_q    <= sticky_d;
            accum_q     <= accum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign ACCUM_OUT = accum_q;
    assign OVF       = ovf_q;
    assign BUSY      = (cnt_q != '0) | s1_valid_q;

endmodule

// File: doc/accum_win.md
# accum_win

Parametrised windowed accumulator for the spatial-filter datapath, the successor to the fixed 48-bit accumulator. Each accepted sample contributes a signed term (A_IN + C_IN), added or subtracted under per-sample control. After WIN_LEN accepted samples the block emits the window sum with a one-cycle valid pulse and restarts with no bubble. Saturation and overflow reporting are selectable. It sits after the kernel-tap multipliers and produces one filtered pixel per window.

## Interface
- IN_W, 24: width of A_IN and C_IN, signed two's complement.
- ACC_W, 48: accumulator and result width. Must be ≥ IN_W+2.
- WIN_LEN, 9: accepted samples per window (9 = 3x3 kernel). Must be ≥ 1.
- SAT_EN, 1: 1 = clamp at signed ACC_W limits; 0 = wrap modulo 2^ACC_W.
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  sample strobe; one sample accepted per cycle while high.
- A_IN  in  IN_W  signed operand A.
- C_IN  in  IN_W  signed operand C.
- ADD_SUB  in  1  0 = add term, 1 = subtract term; sampled with IN_VALID.
- CLR  in  1  synchronous abort of the current window.
- OUT_VALID  out  1  one-cycle pulse when a window result is presented.
- ACCUM_OUT  out  ACC_W  last completed window sum; held between pulses.
- OVF  out  1  overflow/saturation occurred in the window that produced ACCUM_OUT; held with it.
- BUSY  out  1  high while a window is partially accumulated or in flight.

## Operation
- Stage 1 registers:
  - term = sext(A_IN) + sext(C_IN), IN_W+1 bits;
  - the ADD_SUB bit;
  - a valid bit;
  - a last flag, set when the window counter = WIN_LEN-1.
- Window counter counts 0..WIN_LEN-1 and advances on each accepted sample. It wraps to 0 on the last sample.
- Stage 2 (accumulate):
  - The base is 0 on the first term of a window, else the running sum.
  - Compute base ± sext(term) in ACC_W+1 bits.
  - Overflow = the ACC_W+1 result is outside the signed ACC_W range.
  - With SAT_EN=1 the sum clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and accumulation continues from the clamped value.
  - With SAT_EN=0 the sum is truncated (wraps).
  - A sticky window-overflow flag is set on any overflow and cleared at window start.
- On the last term:
  - ACCUM_OUT ← final sum and OVF ← the sticky flag (including the last term's overflow).
  - OUT_VALID pulses for one cycle.
  - The running sum is reseeded by the next window's first term.
- Gaps (IN_VALID low) freeze the counter and the sum; the window resumes on the next accepted sample.
- CLR:
  - Clears the window counter, the stage-1 valid bit, the running sum and the sticky flag.
  - A sample presented in the same cycle as CLR is discarded.
  - A window whose last term is in stage 1 when CLR is high is dropped (no OUT_VALID).
  - ACCUM_OUT and OVF keep their previous values.
- BUSY = (counter ≠ 0) or stage-1 valid.

## Timing
- Reset: OUT_VALID=0, ACCUM_OUT=0, OVF=0, BUSY=0, counter=0, stage-1 valid=0. Reset mid-window discards all partial state.
- Latency: last sample accepted at edge k → stage 1 at k → ACCUM_OUT/OVF/OUT_VALID updated at edge k+1, visible in cycle k+1..k+2. OUT_VALID is low after edge k+2 unless another window completes.
- Throughput: 1 sample/cycle. With WIN_LEN=1, OUT_VALID can be high every cycle. Back-to-back windows need no idle cycle.
- No backpressure: the consumer must take ACCUM_OUT in the OUT_VALID cycle. The value is held afterwards only as a convenience.

## Structure
- Package accum_pkg: default IN_W/ACC_W/WIN_LEN constants; signed-limit constants as functions of ACC_W; a sat_add function shared with other accumulators.
- Sub-module accum_sat_core: combinational ACC_W+1 add/sub with clamp and overflow flag. The top level holds the counter, stage-1 and stage-2 registers.

## Test plan
Defaults IN_W=24, ACC_W=48, WIN_LEN=4 unless stated.
1. RST high then low, no input → all outputs 0; BUSY=0.
2. A=0, C=1, ADD_SUB=0, IN_VALID high for 4 cycles → a single OUT_VALID pulse one edge after the 4th sample; ACCUM_OUT=4, OVF=0. Eight samples give two pulses 4 cycles apart, both 4.
3. Samples (512,514,add), (2020,2000,add), (10,14,sub), (1115,1111,sub) → ACCUM_OUT=2796, OVF=0. Repeat with IN_VALID gaps of 1–3 cycles between them → same 2796.
4. ACC_W=26, A=C=24'h7FFFFF, add ×4 → SAT_EN=1: ACCUM_OUT=33554431, OVF=1. SAT_EN=0: ACCUM_OUT=67108856 mod 2^26 (=−8 signed), OVF=1. The next clean window reports OVF=0.
5. Two samples of 100, then CLR (asserted together with a third sample), then four samples of A=1, C=0 → only one pulse, ACCUM_OUT=4; the prior ACCUM_OUT is held through CLR.
6. Three samples accepted, then RST asserted asynchronously mid-cycle → outputs 0 immediately. After release, four samples of 1 → ACCUM_OUT=4.
